// File: rtl/sync_flywheel.sv
// Line/field timing controller: qualifies raw hsync/vsync strobes through a
// lock FSM and a free-running line flywheel, and regenerates clean hsync,
// line counter, field parity and active-video window. Coasts through missing
// or noisy sync pulses.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   ce        sample enable; all state advances only when ce=1
//   hsync_in  raw hsync, active low
//   vsync_in  raw vsync, active low
//   hsync     regenerated hsync, active low
//   vsync     vsync_in registered one ce-tick, active low
//   line      line number within field
//   hpos      flywheel tick position within line
//   field     field parity
//   active    active-video window
//   locked    1 while the flywheel is locked or coasting
module sync_flywheel #(
    parameter int unsigned LINE_CLKS   = 1536,
    parameter int unsigned HSYNC_CLKS  = 113,
    parameter int unsigned WINDOW      = 32,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned MISS_MAX    = 16,
    parameter int unsigned LINES_FIELD = 312,
    parameter int unsigned VACT_FIRST  = 40,
    parameter int unsigned VACT_LAST   = 295,
    parameter int unsigned HACT_FIRST  = 256,
    parameter int unsigned HACT_LAST   = 1471
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        hsync,
    output logic        vsync,
    output logic [8:0]  line,
    output logic [10:0] hpos,
    output logic        field,
    output logic        active,
    output logic        locked
);

    localparam int unsigned HW  = 11;
    localparam int unsigned LNW = 9;
    localparam int unsigned CW  = 5;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_COAST   = 2'd3
    } state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [CW-1:0]   good_cnt;
    logic [CW-1:0]   miss_cnt;
    logic            hs_prev;
    logic            seen;

    logic            hedge_c;
    logic            vedge_c;
    logic            late_side_c;
    logic            in_win_c;
    logic            miss_c;
    logic            lock_st_c;
    logic            accept_c;
    logic            wrap_c;
    logic            line_inc_c;

    // Edge detection: vsync doubles as the previous vsync_in sample.
    assign hedge_c     = hs_prev & ~hsync_in;
    assign vedge_c     = vsync & ~vsync_in;

    // Acceptance window straddles the expected line start (hcnt wrap).
    assign late_side_c = (hcnt >= HW'(LINE_CLKS - WINDOW));
    assign in_win_c    = late_side_c | (hcnt < HW'(WINDOW));
    assign miss_c      = (hcnt == HW'(WINDOW - 1)) & ~seen;

    assign lock_st_c   = (state == ST_LOCKED) | (state == ST_COAST);
    // Unlocked states take any edge; locked states only in-window ones.
    assign accept_c    = hedge_c & (~lock_st_c | in_win_c);
    assign wrap_c      = (hcnt == HW'(LINE_CLKS - 1));
    // A load from the late side closes the line early; count it there.
    assign line_inc_c  = wrap_c | (accept_c & late_side_c);

    assign hpos        = hcnt;

    // Flywheel, line/field counters, lock FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_SEARCH;
            hcnt     <= '0;
            line     <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            seen     <= 1'b0;
            field    <= 1'b0;
            hs_prev  <= 1'b1;
            vsync    <= 1'b1;
            hsync    <= 1'b1;
            active   <= 1'b0;
            locked   <= 1'b0;
        end else if (ce) begin
            hs_prev <= hsync_in;
            vsync   <= vsync_in;

            if (accept_c || wrap_c) begin
                hcnt <= '0;
            end else begin
                hcnt <= hcnt + HW'(1);
            end

            if (hedge_c && in_win_c) begin
                seen <= 1'b1;
            end else if (hcnt == HW'(WINDOW)) begin
                seen <= 1'b0;
            end

            if (vedge_c) begin
                line <= '0;
                if (lock_st_c) begin
                    field <= (hcnt >= HW'(LINE_CLKS / 2));
                end
            end else if (line_inc_c) begin
                if (line == LNW'(LINES_FIELD - 1)) begin
                    line <= '0;
                end else begin
                    line <= line + LNW'(1);
                end
            end

            case (state)
                ST_SEARCH: begin
                    if (hedge_c) begin
                        good_cnt <= '0;
                        state    <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (hedge_c && in_win_c) begin
                        good_cnt <= good_cnt + CW'(1);
                        if (good_cnt == CW'(LOCK_COUNT - 1)) begin
                            miss_cnt <= '0;
                            state    <= ST_LOCKED;
                        end
                    end else if (hedge_c || miss_c) begin
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (accept_c) begin
                        miss_cnt <= '0;
                    end else if (miss_c) begin
                        miss_cnt <= CW'(1);
                        state    <= ST_COAST;
                    end
                end
                ST_COAST: begin
                    if (accept_c) begin
                        miss_cnt <= '0;
                        state    <= ST_LOCKED;
                    end else if (miss_c) begin
                        miss_cnt <= miss_cnt + CW'(1);
                        if (miss_cnt == CW'(MISS_MAX - 1)) begin
                            good_cnt <= '0;
                            state    <= ST_SEARCH;
                        end
                    end
                end
                default: state <= ST_SEARCH;
            endcase

            hsync  <= lock_st_c ? (hcnt >= HW'(HSYNC_CLKS)) : hsync_in;
            locked <= lock_st_c;
            active <= lock_st_c
                      && (line >= LNW'(VACT_FIRST)) && (line <= LNW'(VACT_LAST))
                      && (hcnt >= HW'(HACT_FIRST)) && (hcnt <= HW'(HACT_LAST));
        end
    end

endmodule
